// File: rtl/ysyx_23060059_refill_ctrl.sv
// rtl/ysyx_23060059_refill_ctrl.sv - cache miss refill controller (evict, writeback, refill, install)
//
// Purpose:
//   Handles one cache miss at a time. Picks the victim way from the replacer,
//   invalidates it, writes it back to memory if dirty, refills the line word by
//   word from memory, installs the new tag and notifies the replacer.
//
// Optional feature macro:
//   YSYX_23060059_REFILL_WRAP_EN - critical-word-first refill (start at the
//   missing word and wrap mod 4). Undefined: refill always starts at beat 0.
//
// Ports:
//   clock, reset                   clock, asynchronous active-low reset
//   miss_valid/miss_ready/miss_addr  miss request handshake and byte address
//   victim_way_i/dirty_i/tag_i       victim info from replacer / tag array
//   wb_data_i                        data array read word (combinational)
//   arr_way_o/arr_idx_o/arr_beat_o   data array address
//   fill_we/fill_data                data array refill write
//   tag_we/tag_valid_o/tag_o         tag array write
//   rep_idx_o/rep_way_o              replacer set / way
//   rep_access_o/rep_invalid_o       replacer one-cycle strobes
//   mem_req_*                        memory word request (valid/ready)
//   mem_rsp_valid/mem_rsp_rdata      memory response (no back-pressure)
//   resp_valid/resp_data             one-cycle miss completion with missed word

module ysyx_23060059_refill_ctrl #(
  parameter  int IDX_W = 3,
  parameter  int WAY_W = 3,
  localparam int TAG_W = 28 - IDX_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             miss_valid,
  output logic             miss_ready,
  input  logic [31:0]      miss_addr,
  input  logic [WAY_W-1:0] victim_way_i,
  input  logic             victim_dirty_i,
  input  logic [TAG_W-1:0] victim_tag_i,
  input  logic [31:0]      wb_data_i,
  output logic [WAY_W-1:0] arr_way_o,
  output logic [IDX_W-1:0] arr_idx_o,
  output logic [1:0]       arr_beat_o,
  output logic             fill_we,
  output logic [31:0]      fill_data,
  output logic             tag_we,
  output logic             tag_valid_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [IDX_W-1:0] rep_idx_o,
  output logic [WAY_W-1:0] rep_way_o,
  output logic             rep_access_o,
  output logic             rep_invalid_o,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic             mem_req_we,
  output logic [31:0]      mem_req_addr,
  output logic [31:0]      mem_req_wdata,
  input  logic             mem_rsp_valid,
  input  logic [31:0]      mem_rsp_rdata,
  output logic             resp_valid,
  output logic [31:0]      resp_data
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOOKUP  = 4'd1,
    S_EVICT   = 4'd2,
    S_WB_REQ  = 4'd3,
    S_WB_RSP  = 4'd4,
    S_RF_REQ  = 4'd5,
    S_RF_RSP  = 4'd6,
    S_INSTALL = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  state_t state_q, state_d;

  // Miss context: word address only, byte offset within a word is irrelevant.
  logic [31:2]      addr_q;
  logic [WAY_W-1:0] way_q;
  logic             dirty_q;
  logic [TAG_W-1:0] vtag_q;
  // Counts beats within the current phase; wraps to 0 after beat 3 so the
  // refill phase starts cleanly after writeback.
  logic [1:0]       cnt_q;
  logic [31:0]      word_q;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [1:0]       off;
  logic [1:0]       rf_beat;
  logic             capture;

  logic unused_byte_off;
  assign unused_byte_off = &{1'b0, miss_addr[1:0]};

  assign idx = addr_q[IDX_W+3:4];
  assign tag = addr_q[31:IDX_W+4];
  assign off = addr_q[3:2];

`ifdef YSYX_23060059_REFILL_WRAP_EN
  // Critical word first: start at the missed word and wrap around the line.
  assign rf_beat = cnt_q + off;
  assign capture = (cnt_q == 2'd0);
`else
  assign rf_beat = cnt_q;
  assign capture = (cnt_q == off);
`endif

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (miss_valid) state_d = S_LOOKUP;
      S_LOOKUP:  state_d = S_EVICT;
      S_EVICT:   state_d = dirty_q ? S_WB_REQ : S_RF_REQ;
      S_WB_REQ:  if (mem_req_ready) state_d = S_WB_RSP;
      S_WB_RSP:  if (mem_rsp_valid) state_d = (cnt_q == 2'd3) ? S_RF_REQ : S_WB_REQ;
      S_RF_REQ:  if (mem_req_ready) state_d = S_RF_RSP;
      S_RF_RSP:  if (mem_rsp_valid) state_d = (cnt_q == 2'd3) ? S_INSTALL : S_RF_REQ;
      S_INSTALL: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath latches
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      way_q   <= '0;
      dirty_q <= 1'b0;
      vtag_q  <= '0;
      cnt_q   <= 2'd0;
      word_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (miss_valid) begin
            addr_q <= miss_addr[31:2];
            cnt_q  <= 2'd0;
          end
        end
        S_LOOKUP: begin
          way_q   <= victim_way_i;
          dirty_q <= victim_dirty_i;
          vtag_q  <= victim_tag_i;
        end
        S_WB_RSP: begin
          if (mem_rsp_valid) cnt_q <= cnt_q + 2'd1;
        end
        S_RF_RSP: begin
          if (mem_rsp_valid) begin
            cnt_q <= cnt_q + 2'd1;
            if (capture) word_q <= mem_rsp_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode
  always_comb begin
    miss_ready    = 1'b0;
    arr_way_o     = '0;
    arr_idx_o     = '0;
    arr_beat_o    = 2'd0;
    fill_we       = 1'b0;
    fill_data     = '0;
    tag_we        = 1'b0;
    tag_valid_o   = 1'b0;
    tag_o         = '0;
    rep_idx_o     = '0;
    rep_way_o     = '0;
    rep_access_o  = 1'b0;
    rep_invalid_o = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    resp_valid    = 1'b0;
    resp_data     = '0;
    case (state_q)
      S_IDLE: begin
        miss_ready = 1'b1;
      end
      S_LOOKUP: begin
        rep_idx_o = idx;
        arr_idx_o = idx;
      end
      S_EVICT: begin
        rep_idx_o     = idx;
        rep_way_o     = way_q;
        rep_invalid_o = 1'b1;
        arr_idx_o     = idx;
        arr_way_o     = way_q;
        tag_we        = 1'b1;
        tag_valid_o   = 1'b0;
        tag_o         = vtag_q;
      end
      S_WB_REQ, S_WB_RSP: begin
        rep_idx_o  = idx;
        arr_idx_o  = idx;
        arr_way_o  = way_q;
        arr_beat_o = cnt_q;
        if (state_q == S_WB_REQ) begin
          mem_req_valid = 1'b1;
          mem_req_we    = 1'b1;
          mem_req_addr  = {vtag_q, idx, cnt_q, 2'b00};
          mem_req_wdata = wb_data_i;
        end
      end
      S_RF_REQ, S_RF_RSP: begin
        rep_idx_o  = idx;
        arr_idx_o  = idx;
        arr_way_o  = way_q;
        arr_beat_o = rf_beat;
        if (state_q == S_RF_REQ) begin
          mem_req_valid = 1'b1;
          mem_req_we    = 1'b0;
          mem_req_addr  = {tag, idx, rf_beat, 2'b00};
        end else if (mem_rsp_valid) begin
          fill_we   = 1'b1;
          fill_data = mem_rsp_rdata;
        end
      end
      S_INSTALL: begin
        rep_idx_o    = idx;
        rep_way_o    = way_q;
        rep_access_o = 1'b1;
        arr_idx_o    = idx;
        arr_way_o    = way_q;
        tag_we       = 1'b1;
        tag_valid_o  = 1'b1;
        tag_o        = tag;
      end
      S_DONE: begin
        resp_valid = 1'b1;
        resp_data  = word_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060059_refill_ctrl.sv
// tb/tb_ysyx_23060059_refill_ctrl.sv - scoreboard bench for the refill controller
module tb_ysyx_23060059_refill_ctrl;
  localparam int IDX_W = 3;
  localparam int WAY_W = 3;
  localparam int TAG_W = 25;
`ifdef YSYX_23060059_REFILL_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             miss_valid = 1'b0;
  logic             miss_ready;
  logic [31:0]      miss_addr = '0;
  logic [WAY_W-1:0] victim_way_i = '0;
  logic             victim_dirty_i = 1'b0;
  logic [TAG_W-1:0] victim_tag_i = '0;
  logic [31:0]      wb_data_i;
  logic [WAY_W-1:0] arr_way_o;
  logic [IDX_W-1:0] arr_idx_o;
  logic [1:0]       arr_beat_o;
  logic             fill_we;
  logic [31:0]      fill_data;
  logic             tag_we, tag_valid_o;
  logic [TAG_W-1:0] tag_o;
  logic [IDX_W-1:0] rep_idx_o;
  logic [WAY_W-1:0] rep_way_o;
  logic             rep_access_o, rep_invalid_o;
  logic             mem_req_valid;
  logic             mem_req_ready = 1'b1;
  logic             mem_req_we;
  logic [31:0]      mem_req_addr, mem_req_wdata;
  logic             mem_rsp_valid = 1'b0;
  logic [31:0]      mem_rsp_rdata = '0;
  logic             resp_valid;
  logic [31:0]      resp_data;

  always #5 clock = ~clock;

  ysyx_23060059_refill_ctrl #(.IDX_W(IDX_W), .WAY_W(WAY_W)) dut (
    .clock(clock), .reset(reset),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .victim_way_i(victim_way_i), .victim_dirty_i(victim_dirty_i), .victim_tag_i(victim_tag_i),
    .wb_data_i(wb_data_i),
    .arr_way_o(arr_way_o), .arr_idx_o(arr_idx_o), .arr_beat_o(arr_beat_o),
    .fill_we(fill_we), .fill_data(fill_data),
    .tag_we(tag_we), .tag_valid_o(tag_valid_o), .tag_o(tag_o),
    .rep_idx_o(rep_idx_o), .rep_way_o(rep_way_o),
    .rep_access_o(rep_access_o), .rep_invalid_o(rep_invalid_o),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .resp_valid(resp_valid), .resp_data(resp_data)
  );

  // Data array model: each word holds its beat number.
  assign wb_data_i = {30'd0, arr_beat_o};

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int t0 = 0;
  int n_acc = 0;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } req_t;
  typedef struct { logic [31:0] data; logic [1:0] beat; } fill_t;
  typedef struct { logic acc; logic [2:0] way; logic [2:0] idx; logic [24:0] tag; int lat; } rep_t;
  typedef struct { logic [31:0] data; int lat; } rsp_t;
  req_t  req_q[$];
  fill_t fill_q[$];
  rep_t  rep_q[$];
  rsp_t  rsp_q[$];

  // Memory stimulus controls
  logic [31:0] stall_addr = 32'hFFFF_FFFF;
  int          stall_left = 0;
  logic [31:0] inj_mask = '0;
  bit          inj_on = 1'b0;
  int          inj_abs = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  // Monitor / scoreboard
  initial begin
    req_t r; fill_t f; rep_t p; rsp_t s;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (miss_valid && miss_ready) begin t0 = cyc; n_acc++; end
        if (mem_req_valid) begin
          if (req_q.size() == 0) fail_now("req_extra");
          else if (mem_req_ready) begin
            r = req_q.pop_front();
            chk("req_we", {31'd0, mem_req_we}, {31'd0, r.we});
            chk("req_addr", mem_req_addr, r.addr);
            if (r.we) chk("req_wdata", mem_req_wdata, r.wdata);
          end else begin
            chk("req_hold_addr", mem_req_addr, req_q[0].addr);
            if (req_q[0].we) chk("req_hold_wdata", mem_req_wdata, req_q[0].wdata);
          end
        end
        if (fill_we) begin
          if (fill_q.size() == 0) fail_now("fill_extra");
          else begin
            f = fill_q.pop_front();
            chk("fill_data", fill_data, f.data);
            chk("fill_beat", {30'd0, arr_beat_o}, {30'd0, f.beat});
          end
        end
        if (rep_access_o && rep_invalid_o) fail_now("rep_both");
        else if (rep_access_o || rep_invalid_o) begin
          if (rep_q.size() == 0) fail_now("rep_extra");
          else begin
            p = rep_q.pop_front();
            chk("rep_kind", {31'd0, rep_access_o}, {31'd0, p.acc});
            chk("rep_way", {29'd0, rep_way_o}, {29'd0, p.way});
            chk("rep_idx", {29'd0, rep_idx_o}, {29'd0, p.idx});
            chk("tag_we", {31'd0, tag_we}, 32'd1);
            chk("tag_valid", {31'd0, tag_valid_o}, {31'd0, p.acc});
            if (p.acc) chk("tag", {7'd0, tag_o}, {7'd0, p.tag});
            chk("rep_lat", cyc - t0, p.lat);
          end
        end else if (tag_we) fail_now("tag_we_alone");
        if (resp_valid) begin
          if (rsp_q.size() == 0) fail_now("resp_extra");
          else begin
            s = rsp_q.pop_front();
            chk("resp_data", resp_data, s.data);
            chk("resp_lat", cyc - t0, s.lat);
          end
        end
      end
    end
  end

  // Memory responder: one cycle after acceptance, data = 0xD000_<addr[15:0]>.
  initial begin
    bit acc; logic [31:0] a; int rel; bit inj;
    forever begin
      @(negedge clock);
      acc = reset && mem_req_valid && mem_req_ready;
      a = mem_req_addr;
      @(posedge clock);
      #1;
      rel = cyc - t0;
      inj = (inj_on && rel >= 0 && rel < 32 && inj_mask[rel]) || (inj_abs == cyc);
      if (acc) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = {16'hD000, a[15:0]};
      end else if (inj) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hBAD0_0000;
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
      end
      if (mem_req_valid && mem_req_addr == stall_addr && stall_left > 0) begin
        mem_req_ready = 1'b0;
        stall_left--;
      end else begin
        mem_req_ready = 1'b1;
      end
    end
  end

  // Push expectations for one miss; nrf limits refill beats (reset abort case).
  task automatic exp_miss(input logic [31:0] addr, input logic [2:0] way, input bit dirty,
                          input logic [24:0] vtag, input int extra, input int nrf, input bit tail);
    logic [2:0] idx; logic [24:0] tag; logic [1:0] off; logic [1:0] b; logic [31:0] ra;
    int base;
    idx = addr[6:4]; tag = addr[31:7]; off = addr[3:2];
    rep_q.push_back('{1'b0, way, idx, 25'd0, 2});
    if (dirty)
      for (int i = 0; i < 4; i++) begin
        b = 2'(i);
        req_q.push_back('{1'b1, {vtag, idx, b, 2'b00}, 32'(i)});
      end
    for (int i = 0; i < nrf; i++) begin
      b = WRAP ? 2'(off + 2'(i)) : 2'(i);
      ra = {tag, idx, b, 2'b00};
      req_q.push_back('{1'b0, ra, 32'd0});
      fill_q.push_back('{{16'hD000, ra[15:0]}, b});
    end
    base = (dirty ? 19 : 11) + extra;
    if (tail) begin
      rep_q.push_back('{1'b1, way, idx, tag, base});
      rsp_q.push_back('{{16'hD000, addr[15:2], 2'b00}, base + 1});
    end
  endtask

  task automatic start_miss(input logic [31:0] addr, input logic [2:0] way, input bit dirty,
                            input logic [24:0] vtag);
    int k;
    miss_addr = addr; victim_way_i = way; victim_dirty_i = dirty; victim_tag_i = vtag;
    miss_valid = 1'b1;
    k = 0;
    do begin
      @(posedge clock); #1; k++;
    end while (miss_ready && k < 50);
    miss_valid = 1'b0;
    if (miss_ready) fail_now("accept_timeout");
  endtask

  task automatic wait_resp();
    int k;
    k = 0;
    while (!resp_valid && k < 200) begin @(posedge clock); #1; k++; end
    if (!resp_valid) fail_now("resp_timeout");
    @(posedge clock); #1;
  endtask

  task automatic chk_empty(input string name);
    chk(name, 32'(req_q.size() + fill_q.size() + rep_q.size() + rsp_q.size()), 32'd0);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_ready"}, {31'd0, miss_ready}, 32'd1);
    chk({name, "_strobes"}, {25'd0, fill_we, tag_we, tag_valid_o, rep_access_o, rep_invalid_o,
                              mem_req_valid, resp_valid}, 32'd0);
    chk({name, "_req"}, mem_req_addr | mem_req_wdata | {31'd0, mem_req_we}, 32'd0);
    chk({name, "_arr"}, {21'd0, arr_way_o, arr_idx_o, arr_beat_o}, 32'd0);
    chk({name, "_rep"}, {26'd0, rep_idx_o, rep_way_o}, 32'd0);
    chk({name, "_data"}, fill_data | resp_data | {7'd0, tag_o}, 32'd0);
  endtask

  initial begin
    int acc0, seen, k;
    repeat (2) @(posedge clock);
    #1;
    chk_idle("reset");
    reset = 1'b1;
    @(posedge clock); #1;
    chk_idle("post_reset");

    // Clean miss, way 5, idx 1: resp at T12
    exp_miss(32'h8000_0014, 3'd5, 1'b0, 25'h0ABC, 0, 4, 1'b1);
    start_miss(32'h8000_0014, 3'd5, 1'b0, 25'h0ABC);
    wait_resp();
    chk_empty("clean_done");

    // Dirty victim, vtag 0x1000: writes 0x80010..1C first, resp at T20
    exp_miss(32'h8000_0018, 3'd2, 1'b1, 25'h1000, 0, 4, 1'b1);
    start_miss(32'h8000_0018, 3'd2, 1'b1, 25'h1000);
    wait_resp();
    chk_empty("dirty_done");

    // Back-pressure: ready low 3 cycles on the beat-2 request
    stall_addr = 32'h8000_0028; stall_left = 3;
    exp_miss(32'h8000_0024, 3'd3, 1'b0, 25'h0001, 3, 4, 1'b1);
    start_miss(32'h8000_0024, 3'd3, 1'b0, 25'h0001);
    wait_resp();
    chk_empty("stall_done");
    chk("stall_used", 32'(stall_left), 32'd0);
    stall_addr = 32'hFFFF_FFFF;

    // Stray responses in IDLE, LOOKUP, INSTALL are ignored
    inj_abs = cyc + 1;
    repeat (3) @(posedge clock);
    #1;
    chk_empty("idle_pulse");
    chk("idle_pulse_ready", {31'd0, miss_ready}, 32'd1);
    inj_mask = (32'd1 << 1) | (32'd1 << 11); inj_on = 1'b1;
    exp_miss(32'h8000_003C, 3'd0, 1'b0, 25'h0002, 0, 4, 1'b1);
    start_miss(32'h8000_003C, 3'd0, 1'b0, 25'h0002);
    wait_resp();
    inj_on = 1'b0; inj_mask = '0;
    chk_empty("inject_done");

    // Reset after refill beat 1, then a fresh full miss
    exp_miss(32'h8000_0014, 3'd5, 1'b0, 25'h0ABC, 0, 2, 1'b0);
    start_miss(32'h8000_0014, 3'd5, 1'b0, 25'h0ABC);
    k = 0;
    while ((cyc - t0) < 7 && k < 50) begin @(posedge clock); #1; k++; end
    reset = 1'b0;
    #1;
    chk_idle("abort");
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk_idle("abort_release");
    chk_empty("abort_queues");
    exp_miss(32'h8000_0014, 3'd5, 1'b0, 25'h0ABC, 0, 4, 1'b1);
    start_miss(32'h8000_0014, 3'd5, 1'b0, 25'h0ABC);
    wait_resp();
    chk_empty("restart_done");

    // miss_valid held high: one acceptance per DONE
    acc0 = n_acc;
    exp_miss(32'h8000_0044, 3'd1, 1'b0, 25'h0003, 0, 4, 1'b1);
    exp_miss(32'h8000_0044, 3'd1, 1'b0, 25'h0003, 0, 4, 1'b1);
    miss_addr = 32'h8000_0044; victim_way_i = 3'd1; victim_dirty_i = 1'b0; victim_tag_i = 25'h0003;
    miss_valid = 1'b1;
    seen = 0; k = 0;
    while (seen < 2 && k < 200) begin
      @(posedge clock); #1; k++;
      if (resp_valid) seen++;
    end
    miss_valid = 1'b0;
    if (seen < 2) fail_now("held_timeout");
    repeat (4) @(posedge clock);
    #1;
    chk("held_accepts", 32'(n_acc - acc0), 32'd2);
    chk_empty("held_done");
    chk_idle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
